// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default sizing, the floor index type and
// index arithmetic used by the call receiver, controller and top.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF      = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef logic [$clog2(NUM_FLOORS_DEF)-1:0] floor_t;

  function automatic int wrap_inc(input int idx, input int num);
    return (idx + 1) % num;
  endfunction

  function automatic int wrap_add(input int base, input int offs, input int num);
    return (base + offs) % num;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One call-button channel: 2-flop synchronizer, stability counter, debounced
// level and a registered one-cycle pulse on each debounced rising edge.
module button_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic rise_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: the level follows the synchronized input only after an unbroken run of disagreement.
  always_comb begin
    sync1_d      = button_i;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = CNT_ZERO;
    level_prev_d = level_q;
    rise_d       = level_q & ~level_prev_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
      cnt_q        <= CNT_ZERO;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      rise_q       <= rise_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/floor_request_rx.sv
// Floor call receiver: debounces call buttons, latches outstanding calls and
// offers them to the controller in round-robin order over a valid/ready handshake.
module floor_request_rx
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] button_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  req_valid_o,
  output floor_t                req_floor_o,
  input  logic                  req_ready_i
);

  logic [NUM_FLOORS-1:0]   rise_s;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  floor_t                  rr_ptr_q, rr_ptr_d;
  logic [2*NUM_FLOORS-1:0] dbl_s;
  logic [NUM_FLOORS-1:0]   rot_s;
  floor_t                  sel_idx_s;
  logic                    valid_s;
  logic                    accept_s;

  generate
    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_chan
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .button_i(button_i[g]),
        .rise_o  (rise_s[g])
      );
    end
  endgenerate

  assign valid_s  = |pending_q;
  assign accept_s = valid_s & req_ready_i;

  // Rotating the pending vector by rr_ptr makes bit k the k-th candidate in search order.
  always_comb begin
    int   sel_int;
    logic found;
    logic hit;
    sel_int = 0;
    found   = 1'b0;
    hit     = 1'b0;
    dbl_s   = {pending_q, pending_q};
    rot_s   = NUM_FLOORS'(dbl_s >> rr_ptr_q);
    for (int k = 0; k < NUM_FLOORS; k++) begin
      hit     = ~found & rot_s[k];
      sel_int = hit ? wrap_add(int'(rr_ptr_q), k, NUM_FLOORS) : sel_int;
      found   = found | hit;
    end
    sel_idx_s = floor_t'(sel_int);
  end

  // Pending and pointer update; a coincident new press overrides the clear of an accepted call.
  always_comb begin
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      pending_d[i] = rise_s[i] |
                     (pending_q[i] & ~(accept_s & (sel_idx_s == floor_t'(i))));
    end
    if (accept_s) begin
      rr_ptr_d = floor_t'(wrap_inc(int'(sel_idx_s), NUM_FLOORS));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Call bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= {NUM_FLOORS{1'b0}};
      rr_ptr_q  <= floor_t'(0);
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign pending_o   = pending_q;
  assign req_valid_o = valid_s;
  assign req_floor_o = valid_s ? sel_idx_s : floor_t'(0);

endmodule
